// File: rtl/ascii_disp_pkg.sv
// ascii_disp_pkg: constants, scan FSM encoding and digit-select helper shared by the display controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascii_disp_pkg;

  // Active-low segment pattern with every segment off.
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  // Character a digit holds until the host writes it.
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  // Upper bound on multiplexed digits; sizes the one-hot helper.
  localparam int         MAX_DIGITS  = 8;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scanState_t;

  // One-hot digit select for a scan index; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/ASCII27Seg.sv
// ASCII27Seg: converts an ASCII code into an active-low seven-segment pattern (bit order g,f,e,d,c,b,a).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   ascii  character code (lower-case letters fold onto upper-case)
//   seg    active-low segment pattern; unsupported characters show a dash
module ASCII27Seg (
  input  logic [7:0] ascii,
  output logic [6:0] seg
);

  logic [7:0] upper;

  always_comb begin
    upper = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      upper = ascii - 8'h20;
    end
  end

  always_comb begin
    seg = 7'h3F;
    case (upper)
      8'h20:   seg = 7'h7F; // space
      8'h2D:   seg = 7'h3F; // -
      8'h5F:   seg = 7'h77; // _
      8'h30:   seg = 7'h40; // 0
      8'h31:   seg = 7'h79; // 1
      8'h32:   seg = 7'h24; // 2
      8'h33:   seg = 7'h30; // 3
      8'h34:   seg = 7'h19; // 4
      8'h35:   seg = 7'h12; // 5
      8'h36:   seg = 7'h02; // 6
      8'h37:   seg = 7'h78; // 7
      8'h38:   seg = 7'h00; // 8
      8'h39:   seg = 7'h10; // 9
      8'h41:   seg = 7'h08; // A
      8'h42:   seg = 7'h03; // b
      8'h43:   seg = 7'h46; // C
      8'h44:   seg = 7'h21; // d
      8'h45:   seg = 7'h06; // E
      8'h46:   seg = 7'h0E; // F
      8'h47:   seg = 7'h42; // G
      8'h48:   seg = 7'h09; // H
      8'h49:   seg = 7'h4F; // I
      8'h4A:   seg = 7'h61; // J
      8'h4C:   seg = 7'h47; // L
      8'h4E:   seg = 7'h2B; // n
      8'h4F:   seg = 7'h23; // o
      8'h50:   seg = 7'h0C; // P
      8'h51:   seg = 7'h18; // q
      8'h52:   seg = 7'h2F; // r
      8'h53:   seg = 7'h12; // S
      8'h54:   seg = 7'h07; // t
      8'h55:   seg = 7'h41; // U
      8'h59:   seg = 7'h11; // y
      default: seg = 7'h3F;
    endcase
  end

endmodule

// File: rtl/scan_tick_timer.sv
// scan_tick_timer: loadable down-counter that times the guard and drive windows of the digit scan.
// Latency: last is combinational from the count; a load takes effect on the next edge.
// Backpressure: none; load has priority over counting.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset (count returns to RST_VAL)
//   load        reload the count from loadVal at the next edge
//   loadVal     window length minus one
//   last        high during the final cycle of the current window
module scan_tick_timer #(
  parameter int CNT_W   = 2,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      // Stops at zero so a missed reload never wraps into a huge window.
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ascii_scan_ctrl.sv
// ascii_scan_ctrl: time-multiplexes NUM_DIGITS seven-segment digits through one shared ASCII converter.
// Latency: each digit is sampled on its last guard edge and lit for DRIVE_CYC cycles; frame = NUM_DIGITS*(GUARD_CYC+DRIVE_CYC).
// Backpressure: none; host writes are always accepted, scan_en low parks the scan blanked on digit 0.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   scan_en            1 = scanning, 0 = all digits blanked, scan held at digit 0
//   wr_en/addr/data    host write port into the per-digit character buffer
//   ascii_code         buffered character of the digit being scanned, to the shared converter
//   seg_in             converter result for ascii_code
//   hex_seg            registered active-low segment drive
//   digit_en           registered one-hot digit enable
//   frame_done         one-cycle pulse after the last digit's drive window
module ascii_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int ADDR_W     = 2,
  parameter int GUARD_CYC  = 2,
  parameter int DRIVE_CYC  = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  output logic [7:0]            ascii_code,
  input  logic [6:0]            seg_in,
  output logic [6:0]            hex_seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  import ascii_disp_pkg::*;

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (GUARD_CYC > DRIVE_CYC) ? GUARD_CYC : DRIVE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scanState_t            state;
  logic [IDX_W-1:0]      scanIdx;
  logic [7:0]            charBuf [NUM_DIGITS];
  logic                  wrHit;
  logic                  tickLast;
  logic                  timerLoad;
  logic [CNT_W-1:0]      timerLoadVal;
  logic [NUM_DIGITS-1:0] scanOneHot;

  // Addresses past the last digit are dropped rather than aliased.
  assign wrHit = wr_en && (int'(wr_addr) < NUM_DIGITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        charBuf[i] <= ASCII_SPACE;
      end
    end else if (wrHit) begin
      charBuf[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // The converter sees the buffer directly, so a write lands on ascii_code the
  // cycle after its edge; the segments only follow at the next guard sample.
  assign ascii_code = charBuf[scanIdx];
  assign scanOneHot = NUM_DIGITS'(onehot(3'(scanIdx)));

  // Reload at every window boundary; scan_en low keeps the timer armed for a
  // full guard window so re-enabling always starts with a blank interval.
  assign timerLoad    = !scan_en || tickLast;
  assign timerLoadVal = (!scan_en || state == DRIVE) ? GUARD_LOAD : DRIVE_LOAD;

  scan_tick_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (GUARD_CYC - 1)
  ) u_tickTimer (
    .clk     (clk),
    .reset   (reset),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .last    (tickLast)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GUARD;
      scanIdx    <= '0;
      hex_seg    <= SEG_BLANK;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!scan_en) begin
        state    <= GUARD;
        scanIdx  <= '0;
        hex_seg  <= SEG_BLANK;
        digit_en <= '0;
      end else if (tickLast) begin
        case (state)
          GUARD: begin
            // Segments and enable switch on the same edge, so the digit
            // never shows the previous digit's pattern.
            hex_seg  <= seg_in;
            digit_en <= scanOneHot;
            state    <= DRIVE;
          end
          DRIVE: begin
            hex_seg  <= SEG_BLANK;
            digit_en <= '0;
            state    <= GUARD;
            if (scanIdx == LAST_IDX) begin
              scanIdx    <= '0;
              frame_done <= 1'b1;
            end else begin
              scanIdx <= scanIdx + IDX_W'(1);
            end
          end
          default: state <= GUARD;
        endcase
      end
    end
  end

  aOneHotEn: assert property (@(posedge clk) disable iff (reset) $onehot0(digit_en));
  aDarkInGuard: assert property (@(posedge clk) disable iff (reset)
    (state == GUARD) |-> (digit_en == '0));
  aBlankWhenDark: assert property (@(posedge clk) disable iff (reset)
    (digit_en == '0) |-> (hex_seg == SEG_BLANK));

endmodule

// File: tb/tb_ascii_scan_ctrl.sv
// tb_ascii_scan_ctrl: scoreboard bench for ascii_scan_ctrl with 4 digits, 1 guard and 3 drive cycles.
// Latency: a phase-based model predicts every output cycle; predictions are queued at each edge and compared at the following negedge.
// Backpressure: n/a.
module tb_ascii_scan_ctrl;

  localparam int ND  = 4;
  localparam int GC  = 1;
  localparam int DC  = 3;
  localparam int PER = GC + DC;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] en;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic       clk;
  logic       reset = 1'b1;
  logic       scan_en;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ascii_code;
  logic [6:0] seg_in;
  logic [6:0] hex_seg;
  logic [3:0] digit_en;
  logic       frame_done;
  logic [7:0] refCode;
  logic [6:0] refSeg;

  logic [6:0] segTab [256];
  logic [7:0] mBuf [ND];
  logic [6:0] mSeg;
  int         phase;
  exp_t       expQ [$];
  int         passCnt = 0;
  int         checkCnt = 0;

  ascii_scan_ctrl #(
    .NUM_DIGITS (ND),
    .ADDR_W     (2),
    .GUARD_CYC  (GC),
    .DRIVE_CYC  (DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ascii_code (ascii_code),
    .seg_in     (seg_in),
    .hex_seg    (hex_seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  ASCII27Seg conv (.ascii(ascii_code), .seg(seg_in));
  ASCII27Seg refConv (.ascii(refCode), .seg(refSeg));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Output expected during the cycle at the current scan phase: phase 0 is the
  // first guard cycle of digit 0 after reset or after scan_en was low.
  function automatic exp_t predict();
    exp_t e;
    int   slot = phase % PER;
    int   dig  = (phase / PER) % ND;
    logic lit  = (slot >= GC);
    e.code = mBuf[dig];
    e.en   = lit ? 4'(1 << dig) : 4'b0000;
    e.seg  = lit ? mSeg : 7'h7F;
    e.fd   = (phase != 0) && ((phase % (PER * ND)) == 0);
    return e;
  endfunction

  // Reference model: advance one cycle per edge, then queue the prediction.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        phase = 0;
        mSeg  = 7'h7F;
        for (int i = 0; i < ND; i++) mBuf[i] = 8'h20;
        expQ.delete();
      end else begin
        if (scan_en && (phase % PER) == GC - 1) mSeg = segTab[mBuf[(phase / PER) % ND]];
        if (wr_en) mBuf[wr_addr] = wr_data;
        phase = scan_en ? phase + 1 : 0;
      end
      expQ.push_back(predict());
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkVal("ascii_code", 32'(ascii_code), 32'(e.code));
        checkVal("digit_en",   32'(digit_en),   32'(e.en));
        checkVal("hex_seg",    32'(hex_seg),    32'(e.seg));
        checkVal("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle of the next
  // lit window for pat.
  task automatic waitLit(input logic [3:0] pat, input string tag);
    int n = 0;
    while (digit_en == pat && n < 80) begin @(negedge clk); n++; end
    while (digit_en != pat && n < 80) begin @(negedge clk); n++; end
    checkVal(tag, 32'(digit_en), 32'(pat));
  endtask

  initial begin
    int fdCnt;
    scan_en = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      refCode = 8'(i);
      #1;
      segTab[i] = refSeg;
    end

    // Reset held, then one guard cycle before digit 0 lights for 3 cycles.
    @(negedge clk);
    checkVal("rstAscii", 32'(ascii_code), 32'h20);
    checkVal("rstEn",    32'(digit_en),   32'h0);
    checkVal("rstSeg",   32'(hex_seg),    32'h7F);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkVal("guard0", 32'(digit_en), 32'h0);
    repeat (3) begin
      @(negedge clk);
      checkVal("lit0Hold", 32'(digit_en), 32'h1);
    end
    @(negedge clk);
    checkVal("dark0", 32'(digit_en), 32'h0);

    // Load "0123" while blanked, then scan two full frames.
    scan_en = 1'b0;
    for (int i = 0; i < ND; i++) begin
      wr_en   = 1'b1;
      wr_addr = 2'(i);
      wr_data = 8'h30 + 8'(i);
      @(negedge clk);
    end
    wr_en   = 1'b0;
    scan_en = 1'b1;
    fdCnt   = 0;
    repeat (32) begin
      @(negedge clk);
      if (frame_done) fdCnt++;
    end
    checkVal("framePulses", 32'(fdCnt), 32'd2);
    waitLit(4'b0001, "litDig0");
    checkVal("seg0", 32'(hex_seg), 32'(segTab[8'h30]));

    // Rewrite the lit digit 2: old pattern holds until its next sample.
    waitLit(4'b0100, "litDig2");
    wr_en   = 1'b1;
    wr_addr = 2'd2;
    wr_data = 8'h39;
    @(negedge clk);
    wr_en = 1'b0;
    checkVal("hold2", 32'(hex_seg), 32'(segTab[8'h32]));
    waitLit(4'b0100, "relitDig2");
    checkVal("seg9", 32'(hex_seg), 32'(segTab[8'h39]));

    // Write digit 3 on the edge that samples it: old char this frame.
    repeat (3) @(negedge clk);
    checkVal("guard3", 32'(digit_en), 32'h0);
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 8'h41;
    @(negedge clk);
    wr_en = 1'b0;
    checkVal("lit3",     32'(digit_en),   32'h8);
    checkVal("oldSeg3",  32'(hex_seg),    32'(segTab[8'h33]));
    checkVal("newCode3", 32'(ascii_code), 32'h41);
    waitLit(4'b1000, "relitDig3");
    checkVal("newSeg3", 32'(hex_seg), 32'(segTab[8'h41]));

    // Drop scan_en mid-drive of digit 1, then re-enable.
    waitLit(4'b0010, "litDig1");
    @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    checkVal("offEn",  32'(digit_en), 32'h0);
    checkVal("offSeg", 32'(hex_seg),  32'h7F);
    repeat (3) @(negedge clk);
    scan_en = 1'b1;
    @(negedge clk);
    checkVal("reEn",  32'(digit_en), 32'h1);
    checkVal("reSeg", 32'(hex_seg),  32'(segTab[8'h30]));

    // Asynchronous reset while digit 3 is lit; buffer returns to spaces.
    waitLit(4'b1000, "litDig3b");
    #2 reset = 1'b1;
    #1;
    checkVal("asyncEn",    32'(digit_en),   32'h0);
    checkVal("asyncSeg",   32'(hex_seg),    32'h7F);
    checkVal("asyncAscii", 32'(ascii_code), 32'h20);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/ascii_scan_ctrl.md
Name: ascii_scan_ctrl

Overview:
Time-multiplexed display controller that shares one ASCII27Seg converter across NUM_DIGITS seven-segment digits.
- Holds a per-digit ASCII character buffer, written by a host port.
- Steps a scan index through the digits and presents each stored code to the external shared converter.
- Registers the converter's segment output and drives one-hot digit enables, with a blanking guard interval between digits to prevent ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- ADDR_W, 2, width of wr_addr; must satisfy 2^ADDR_W >= NUM_DIGITS.
- GUARD_CYC, 2, blanking cycles before each digit is lit (>=1).
- DRIVE_CYC, 50000, cycles each digit stays lit (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- scan_en  input  1  1 = scanning; 0 = all digits blanked and scan held at digit 0.
- wr_en  input  1  write strobe for the character buffer (single cycle, always accepted).
- wr_addr  input  ADDR_W  digit index to write.
- wr_data  input  8  ASCII code to store.
- ascii_code  output  8  to shared converter input; combinational read of buf[scan_idx].
- seg_in  input  7  segment pattern returned by the shared converter (combinational from ascii_code).
- hex_seg  output  7  registered segment drive, active-low.
- digit_en  output  NUM_DIGITS  registered one-hot digit enable, active-high.
- frame_done  output  1  one-cycle pulse when the last digit finishes its drive window.

Behaviour:
Reset (async, while reset high):
- buf[all] = 8'h20 (space); scan_idx = 0; state = GUARD; tick_cnt = 0.
- hex_seg = 7'h7F; digit_en = 0; frame_done = 0.

FSM states: GUARD, DRIVE.
- GUARD:
  - digit_en = 0; ascii_code = buf[scan_idx]; tick_cnt counts 0..GUARD_CYC-1.
  - On the final GUARD cycle, at the clock edge: hex_seg <= seg_in; digit_en <= one-hot(scan_idx); state -> DRIVE; tick_cnt -> 0.
- DRIVE:
  - hex_seg and digit_en held; tick_cnt counts 0..DRIVE_CYC-1.
  - On the final DRIVE cycle, at the clock edge: digit_en <= 0; hex_seg <= 7'h7F; scan_idx <= (scan_idx == NUM_DIGITS-1) ? 0 : scan_idx+1; state -> GUARD.
  - frame_done <= 1 for exactly one cycle when the wrapping digit was NUM_DIGITS-1.

Timing:
- Per-digit period = GUARD_CYC + DRIVE_CYC cycles.
- Frame period = NUM_DIGITS * (GUARD_CYC + DRIVE_CYC) cycles.
- Digit k lights exactly GUARD_CYC cycles after the previous digit goes dark.

Buffer writes:
- buf[wr_addr] <= wr_data on the edge where wr_en = 1. Visible on ascii_code the next cycle.
- Writes with wr_addr >= NUM_DIGITS are ignored.
- A write to the currently lit digit does not change hex_seg until that digit's next GUARD sample.
- A write in the same cycle as the GUARD sample edge: the sample uses the old value.

scan_en:
- scan_en = 0 in any state forces, at the next edge: state = GUARD, tick_cnt = 0, scan_idx = 0, digit_en = 0, hex_seg = 7'h7F, no frame_done.
- Writes are still accepted while scan_en = 0.
- When scan_en rises, the full GUARD interval for digit 0 runs first.

Reset mid-operation: outputs go to reset values immediately (async); buffer contents are lost.

Invariants:
- digit_en is never multi-hot.
- digit_en is never nonzero in GUARD.
- hex_seg is never non-blank while digit_en = 0.

Decomposition:
- Shared package ascii_disp_pkg:
  - SEG_BLANK = 7'h7F; ASCII_SPACE = 8'h20.
  - state encoding (GUARD = 1'b0, DRIVE = 1'b1).
  - helper function onehot(idx).
- One natural sub-module: scan_tick_timer.
  - Loadable down-counter sized $clog2(max(GUARD_CYC, DRIVE_CYC)) bits; emits "last" on the final count.
- The ASCII27Seg converter is instantiated at the top level, outside this block, so it stays shareable.

Test Plan:
Bench parameters: NUM_DIGITS=4, GUARD_CYC=1, DRIVE_CYC=3; ASCII27Seg instance wired to ascii_code/seg_in; expected segments taken from a reference ASCII27Seg instance.

1. Reset with scan_en=1:
   - ascii_code=8'h20, digit_en=0, hex_seg=7'h7F during reset.
   - After release, digit_en=4'b0001 on the 2nd edge, held 3 cycles.
2. Write 8'h30,8'h31,8'h32,8'h33 to addr 0..3, then scan:
   - digit_en sequence 0001,0000,0010,0000,0100,0000,1000, 4-cycle period.
   - hex_seg equals the converter output for '0'..'3' in matching slots.
   - frame_done pulses once per 16 cycles.
3. While digit 2 is lit, write addr 2 = 8'h39:
   - hex_seg unchanged until the next frame.
   - Then hex_seg shows the pattern for '9'.
4. Drop scan_en mid-DRIVE of digit 1:
   - Next edge: digit_en=0, hex_seg=7'h7F.
   - On re-enable, digit 0 lights after 1 guard cycle.
5. wr_addr=3 with wr_en and GUARD sample of digit 3 on the same edge: old character displayed this frame, new one next frame.
6. Assert reset while digit 3 is lit: digit_en=0 and hex_seg=7'h7F asynchronously, before the next edge; buffer reads back 8'h20.
